ex_div_ctrl: RTL

Multi-cycle divide sequencer for the execute stage. Accepts a LoongArch `div.w`/`mod.w`/`div.wu`/`mod.wu` operation that the stage has presented, then runs an iterative restoring divider, one quotient bit per cycle. While the divide runs it holds the stage's `ready_go` low, so the pipeline stalls. It then holds the result until the memory stage accepts the instruction.

---
 rtl/div_pkg.sv | 50 +++++
 rtl/div_core.sv | 124 ++++++++++++
 rtl/ex_div_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared constants, types and helpers for the execute-stage divider
//           (FSM state encoding, div_op encodings, iteration count and the
//           divide-by-zero quotient pattern).
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // div_op encodings (LoongArch div.w / mod.w / div.wu / mod.wu)
    localparam logic [1:0] OP_DIV_W  = 2'b00;
    localparam logic [1:0] OP_MOD_W  = 2'b01;
    localparam logic [1:0] OP_DIV_WU = 2'b10;
    localparam logic [1:0] OP_MOD_WU = 2'b11;

    // One quotient bit per iteration, so the iteration count is the width
    localparam int DIV_ITERS = 32;

    // Quotient returned for a zero divisor
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    // Per-operation attributes captured when a divide is started
    typedef struct packed {
        logic is_mod;   // result is the remainder rather than the quotient
        logic q_neg;    // quotient must be negated at the end
        logic r_neg;    // remainder must be negated at the end
        logic dbz;      // divisor was zero
    } div_flags_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV_W) || (op == OP_MOD_W);
    endfunction

    function automatic logic op_is_mod(input logic [1:0] op);
        return (op == OP_MOD_W) || (op == OP_MOD_WU);
    endfunction

    function automatic logic op_is_unsigned_div(input logic [1:0] op);
        return (op == OP_DIV_WU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : div_core
// Brief   : Restoring shift/subtract divider datapath. Holds the remainder,
//           quotient and divisor registers, the captured operation flags and
//           applies sign fixup / divide-by-zero substitution to the result.
//           Optional feature macro: DIV_EARLY_EXIT_EN (skip the iterations
//           when the divisor is zero or the dividend magnitude is smaller).
// Revision: 1.0 - initial release
// ============================================================================
module div_core
    import div_pkg::*;
#(
    parameter int XLEN = DIV_ITERS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            skip,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] DBZ_Q = XLEN'(DIV_BY_ZERO_Q);

    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;

    // rem is one bit wider than the operands so the shifted partial
    // remainder can be compared and subtracted without overflow
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] src1_raw;
    div_flags_t      flags;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_sub;
    logic            rem_ge;
    logic [XLEN-1:0] rem_lo;
    logic            unused_rem_msb;

    // Operand signs and magnitudes; unsigned ops pass the raw operand through
    always_comb begin
        sign1 = op_is_signed(op) & src1[XLEN-1];
        sign2 = op_is_signed(op) & src2[XLEN-1];
        mag1  = sign1 ? -src1 : src1;
        mag2  = sign2 ? -src2 : src2;
    end

    // Decide whether the iterations can be skipped for this operand pair
    always_comb begin
`ifdef DIV_EARLY_EXIT_EN
        skip = (mag2 == '0) || (mag1 < mag2);
`else
        skip = 1'b0;
`endif
    end

    // One restoring-division step: shift {rem, quo} left, trial subtract
    always_comb begin
        rem_shift = {rem[XLEN-1:0], quo[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, divisor};
        rem_ge    = (rem_shift >= {1'b0, divisor});
    end

    // Datapath registers: capture operands on load, iterate on step
    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            src1_raw <= '0;
            flags    <= '0;
        end else if (load) begin
            divisor      <= mag2;
            src1_raw     <= src1;
            flags.is_mod <= op_is_mod(op);
            flags.q_neg  <= sign1 ^ sign2;
            flags.r_neg  <= sign1;
            flags.dbz    <= (src2 == '0);
            if (skip) begin
                // Quotient is zero and the dividend is already the remainder
                quo <= '0;
                rem <= {1'b0, mag1};
            end else begin
                quo <= mag1;
                rem <= '0;
            end
        end else if (step) begin
            if (rem_ge) begin
                rem <= rem_sub;
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= rem_shift;
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Final result: divide-by-zero substitution, otherwise sign fixup
    always_comb begin
        rem_lo = rem[XLEN-1:0];
        if (flags.dbz) begin
            result = flags.is_mod ? src1_raw : DBZ_Q;
        end else if (flags.is_mod) begin
            result = flags.r_neg ? -rem_lo : rem_lo;
        end else begin
            result = flags.q_neg ? -quo : quo;
        end
    end

    // The remainder MSB is only headroom for the trial subtract; between
    // iterations the stored remainder is always below the divisor
    assign unused_rem_msb = rem[XLEN];

endmodule
`default_nettype wire

// File: rtl/ex_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ex_div_ctrl
// Brief   : Execute-stage divide sequencer. IDLE/CALC/DONE FSM, iteration
//           counter, cancel handling and ex_ready_go generation around the
//           div_core datapath. Optional feature macro: DIV_EARLY_EXIT_EN
//           (handled inside div_core; lets IDLE jump straight to DONE).
// Revision: 1.0 - initial release
// ============================================================================
module ex_div_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_ITERS,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_valid,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_src1,
    input  logic [XLEN-1:0] div_src2,
    input  logic            div_cancel,
    input  logic            mem_allow_in,
    output logic            ex_ready_go,
    output logic            div_busy,
    output logic [XLEN-1:0] div_result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             start;
    logic             skip;
    logic [XLEN-1:0]  core_result;

    // A divide starts only from IDLE and only if it is not being squashed
    always_comb begin
        start = (state == ST_IDLE) & div_valid & ~div_cancel;
    end

    // Next-state logic; cancel overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = skip ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_nx = ST_DONE;
            ST_DONE: if (div_valid & mem_allow_in) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (div_cancel) begin
            state_nx = ST_IDLE;
        end
    end

    // State register and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (start | div_cancel) begin
                cnt <= '0;
            end else if ((state == ST_CALC) && (cnt != LAST_ITER)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    div_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (start),
        .step   (state == ST_CALC),
        .op     (div_op),
        .src1   (div_src1),
        .src2   (div_src2),
        .skip   (skip),
        .result (core_result)
    );

    // Stage handshake and status outputs; the result is only driven in DONE
    always_comb begin
        ex_ready_go = ~div_valid | (state == ST_DONE);
        div_busy    = (state == ST_CALC);
        div_result  = (state == ST_DONE) ? core_result : '0;
    end

endmodule
`default_nettype wire
